// File: rtl/ramb_sp_param.sv
// Parametrised single-port synchronous block RAM with byte-lane write enables,
// selectable write mode, optional output register and programmable reset value.
module ramb_sp_param #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    BYTE_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 10,
    parameter string                 WRITE_MODE = "WRITE_FIRST",
    parameter int                    DO_REG     = 0,
    parameter logic [DATA_WIDTH-1:0] SRVAL      = '0,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               EN,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   WE,
    input  logic                               REGCE,
    input  logic [ADDR_WIDTH-1:0]              ADDR,
    input  logic [DATA_WIDTH-1:0]              DI,
    output logic [DATA_WIDTH-1:0]              DO
);

    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int MODE  = (WRITE_MODE == "WRITE_FIRST") ? 0 :
                           (WRITE_MODE == "READ_FIRST")  ? 1 :
                           (WRITE_MODE == "NO_CHANGE")   ? 2 : 3;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("ramb_sp_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (MODE == 3) begin : g_bad_mode
        $error("ramb_sp_param: WRITE_MODE must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_VAL};
    logic [DATA_WIDTH-1:0] rd_latch    = SRVAL;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic                  any_we;
    logic                  addr_x;

    assign old_word = mem[ADDR];
    assign any_we   = |WE;
    assign addr_x   = $isunknown(ADDR);

    // Word as it looks after this edge's write: new lanes where enabled, old lanes elsewhere.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
            WE[i] ? DI[i*BYTE_WIDTH +: BYTE_WIDTH] : old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    // An unknown address on a write poisons the whole array; RST never blocks the write.
    always_ff @(posedge CLK) begin
        if (EN && any_we) begin
            if (addr_x) begin
                for (int k = 0; k < DEPTH; k++) begin
                    mem[k] <= 'x;
                end
            end else begin
                mem[ADDR] <= merged_word;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (EN) begin
            if (RST) begin
                rd_latch <= SRVAL;
            end else if (addr_x) begin
                rd_latch <= 'x;
            end else if (!any_we) begin
                rd_latch <= old_word;
            end else if (MODE == 0) begin
                rd_latch <= merged_word;
            end else if (MODE == 1) begin
                rd_latch <= old_word;
            end
        end
    end

    // Optional pipeline register; its reset does not depend on EN or REGCE.
    if (DO_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_reg = SRVAL;

        always_ff @(posedge CLK) begin
            if (RST) begin
                out_reg <= SRVAL;
            end else if (REGCE) begin
                out_reg <= rd_latch;
            end
        end

        assign DO = out_reg;
    end else begin : g_out_direct
        logic unused_regce;
        assign unused_regce = REGCE;
        assign DO           = rd_latch;
    end

endmodule
